digital_transmitter: RTL and testbench

DIGITAL_TRANSMITTER -- requirements
Module: digital_transmitter

---
 rtl/dtx_pkg.sv | 8 +
 rtl/dtx_bitclk.sv | 20 ++
 rtl/digital_transmitter.sv | 84 ++++++++
 tb/tb_digital_transmitter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dtx_pkg.sv
// dtx_pkg: shared state encoding, default parameters and counter width for digital_transmitter
package dtx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int CLK_DIV_DEF = 4;
  localparam int WORD_BITS_DEF = 12;
  localparam int FRAME_WORDS_DEF = 32;
  localparam int UCNT_W = 16;
endpackage

// File: rtl/dtx_bitclk.sv
// dtx_bitclk: bit-period divider producing dCLK (low half then high half) and an end-of-bit strobe
module dtx_bitclk import dtx_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic dclk,
  output logic bit_end
);
  localparam int CW = $clog2(2 * CLK_DIV);
  logic [CW-1:0] cnt_q;
  assign bit_end = run && cnt_q == CW'(2 * CLK_DIV - 1);
  assign dclk = cnt_q >= CW'(CLK_DIV);
  // phase counter parks at zero whenever not shifting, so each word restarts on a low half
  always_ff @(posedge clk) begin
    if (reset || !run || bit_end) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/digital_transmitter.sv
// digital_transmitter: framed MSB-first serial word transmitter; define DTX_PARITY_EN to append an odd-parity bit per word
module digital_transmitter import dtx_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 dCLK,
  output logic                 dDAT,
  output logic                 dFM,
  output logic                 frame_start,
  output logic [UCNT_W-1:0]    underrun_cnt,
  output logic                 busy
);
`ifdef DTX_PARITY_EN
  localparam int NB = WORD_BITS + 1;
`else
  localparam int NB = WORD_BITS;
`endif
  localparam int BW = $clog2(NB + 1);
  localparam int WW = $clog2(FRAME_WORDS);
  state_t state_q;
  logic [NB-1:0] sh_q;
  logic [BW-1:0] bit_q;
  logic [WW-1:0] word_q;
  logic [UCNT_W-1:0] ucnt_q;
  logic [WORD_BITS-1:0] fill;
  logic [NB-1:0] load_d;
  logic bit_end, last_word;
  assign fill = word_valid ? word_data : '0;
`ifdef DTX_PARITY_EN
  assign load_d = {fill, ~^fill};
`else
  assign load_d = fill;
`endif
  assign last_word = word_q == WW'(FRAME_WORDS - 1);
  dtx_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
    .clk(clk), .reset(reset), .run(state_q == SHIFT), .dclk(dCLK), .bit_end(bit_end)
  );
  assign busy = state_q != IDLE;
  assign word_ready = state_q == LOAD;
  assign frame_start = word_ready && word_q == '0;
  assign dDAT = state_q == SHIFT && sh_q[NB-1];
  assign dFM = state_q == SHIFT && word_q == '0;
  assign underrun_cnt = ucnt_q;
  // sequencer: one LOAD cycle per word, then NB bit periods; enable only sampled between frames
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      word_q <= '0;
      ucnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          state_q <= LOAD;
          word_q <= '0;
        end
        LOAD: begin
          state_q <= SHIFT;
          sh_q <= load_d;
          bit_q <= '0;
          if (!word_valid && ucnt_q != '1) ucnt_q <= ucnt_q + 1'b1;
        end
        SHIFT: if (bit_end) begin
          if (bit_q == BW'(NB - 1)) begin
            word_q <= last_word ? '0 : word_q + 1'b1;
            state_q <= (last_word && !enable) ? IDLE : LOAD;
          end else begin
            sh_q <= sh_q << 1;
            bit_q <= bit_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digital_transmitter.sv
// tb_digital_transmitter: randomized and directed bench with a positional reference model
module tb_digital_transmitter;
  localparam int CD = 4, WB = 12, FW = 4;
`ifdef DTX_PARITY_EN
  localparam int NB = WB + 1;
`else
  localparam int NB = WB;
`endif
  localparam int WL = 1 + NB * 2 * CD;
  logic clk = 0, reset = 1, enable = 0, word_valid = 0;
  logic [WB-1:0] word_data = '0;
  logic word_ready, dCLK, dDAT, dFM, frame_start, busy;
  logic [15:0] underrun_cnt;
  int checks = 0, errors = 0, cyc = 0;
  bit m_chk = 0, m_run = 0;
  int m_pos = 0, m_widx = 0;
  logic [NB-1:0] m_val = '0;
  logic [WB-1:0] m_fill;
  logic [15:0] m_ucnt = '0;
  logic [NB-1:0] v;
  logic fm;
  int c0, n;

  always #5 clk = ~clk;

  digital_transmitter #(.CLK_DIV(CD), .WORD_BITS(WB), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .dCLK(dCLK), .dDAT(dDAT), .dFM(dFM), .frame_start(frame_start),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sig(input int which, input string name);
    int t = 0;
    while (!(which == 0 ? word_ready : which == 1 ? frame_start : !busy)) begin
      step(1);
      t++;
      if (t > 3000) begin
        checks++;
        errors++;
        $display("FAIL timeout %s: got no event expected one within 3000 cycles", name);
        return;
      end
    end
  endtask

  task automatic send_capture(input logic vld, input logic [WB-1:0] d, output logic [NB-1:0] bits, output logic fm_all);
    wait_sig(0, "word_ready");
    word_valid = vld;
    word_data = d;
    step(1);
    word_valid = 1;
    step(CD);
    fm_all = 1;
    for (int b = 0; b < NB; b++) begin
      if (b > 0) step(2 * CD);
      check("dCLK_rise", dCLK, 1);
      bits[NB-1-b] = dDAT;
      fm_all = fm_all & dFM;
    end
  endtask

  // reference model: position within the word and the frame, updated from sampled inputs
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_run = 0; m_pos = 0; m_widx = 0; m_ucnt = 0;
    end else if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; m_widx = 0; end
    end else if (m_pos == 0) begin
      m_fill = word_valid ? word_data : '0;
`ifdef DTX_PARITY_EN
      m_val = {m_fill, 1'(($countones(m_fill) % 2) == 0)};
`else
      m_val = m_fill;
`endif
      if (!word_valid && m_ucnt != 16'hFFFF) m_ucnt++;
      m_pos = 1;
    end else if (m_pos == WL - 1) begin
      if (m_widx == FW - 1 && !enable) m_run = 0;
      m_widx = (m_widx + 1) % FW;
      m_pos = 0;
    end else m_pos++;
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    int k, bidx;
    bit sh;
    if (m_chk) begin
      k = m_pos - 1;
      sh = m_run && m_pos > 0;
      bidx = sh ? NB - 1 - k / (2 * CD) : 0;
      check("busy", busy, m_run);
      check("word_ready", word_ready, m_run && m_pos == 0);
      check("frame_start", frame_start, m_run && m_pos == 0 && m_widx == 0);
      check("dCLK", dCLK, sh && (k % (2 * CD)) >= CD);
      check("dDAT", dDAT, sh && m_val[bidx]);
      check("dFM", dFM, sh && m_widx == 0);
      check("underrun_cnt", underrun_cnt, m_ucnt);
    end
  end

  initial begin
    @(posedge clk);
    #1 m_chk = 1;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_dCLK", dCLK, 0);
    check("rst_dDAT", dDAT, 0);
    check("rst_dFM", dFM, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun_cnt, 0);

    reset = 0; enable = 1; word_valid = 1;
    send_capture(1, 12'hA5C, v, fm);
    check("a5c_bits", v[NB-1 -: WB], 12'hA5C);
    check("a5c_dFM", fm, 1);
`ifdef DTX_PARITY_EN
    check("a5c_parity", v[0], 1);
`endif

    word_data = 12'h3C7;
    wait_sig(1, "frame_start");
    c0 = cyc;
    step(1);
    wait_sig(1, "frame_start");
`ifdef DTX_PARITY_EN
    check("frame_period", cyc - c0, 420);
`else
    check("frame_period", cyc - c0, 388);
`endif

    wait_sig(1, "frame_start");
    step(1);
    wait_sig(0, "word1_ready");
    step(5);
    enable = 0;
    n = 0;
    for (int i = 0; i < 3000 && busy; i++) begin
      step(1);
      if (word_ready) n++;
    end
    check("drop_words_after", n, 2);
    check("drop_busy", busy, 0);
    check("drop_dCLK", dCLK, 0);

    reset = 1; step(2); reset = 0; enable = 1;
    for (int i = 0; i < 3; i++) begin
      send_capture(0, 12'hFFF, v, fm);
      check("zero_fill_data", v[NB-1 -: WB], 0);
`ifdef DTX_PARITY_EN
      check("zero_fill_parity", v[0], 1);
`endif
    end
    check("underrun_3", underrun_cnt, 3);

    force dut.ucnt_q = 16'hFFFE;
    m_ucnt = 16'hFFFE;
    #1 release dut.ucnt_q;
    for (int i = 0; i < 3; i++) send_capture(0, 12'h123, v, fm);
    check("underrun_sat", underrun_cnt, 16'hFFFF);

`ifdef DTX_PARITY_EN
    send_capture(1, 12'h001, v, fm);
    check("parity_001", v[0], 0);
    send_capture(1, 12'h003, v, fm);
    check("parity_003", v[0], 1);
`endif

    reset = 1; step(1); reset = 0; enable = 1; word_valid = 1;
    wait_sig(0, "word_ready_pre_reset");
    step(1 + 5 * 2 * CD + 2);
    reset = 1;
    step(1);
    check("midrst_busy", busy, 0);
    check("midrst_dCLK", dCLK, 0);
    check("midrst_dDAT", dDAT, 0);
    check("midrst_dFM", dFM, 0);
    check("midrst_underrun", underrun_cnt, 0);
    reset = 0;
    wait_sig(0, "word_ready_post_reset");
    check("midrst_frame_start", frame_start, 1);
    step(1);
    check("midrst_dFM_word0", dFM, 1);

    for (int i = 0; i < 4000; i++) begin
      word_data = WB'($urandom);
      word_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      reset = $urandom_range(0, 1999) == 0;
      step(1);
    end
    reset = 0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
